// File: rtl/audio_buffer_scheduler.sv
// rtl/audio_buffer_scheduler.sv - sample-rate scheduler and stereo pair FIFO for audioport playback
module audio_buffer_scheduler #(
  parameter int BUFFER_DEPTH = 16,
  parameter int DIV_W        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          play_in,
  input  logic                          clr_in,
  input  logic [DIV_W-1:0]              rate_div_in,
  input  logic                          wr_in,
  input  logic [47:0]                   wdata_in,
  input  logic                          irq_ack_in,
  output logic [1:0][23:0]              abuf_out,
  output logic                          tick_out,
  output logic                          irq_out,
  output logic [$clog2(BUFFER_DEPTH):0] level_out,
  output logic                          full_out,
  output logic                          underrun_out,
  output logic                          wr_err_out
);

  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(BUFFER_DEPTH);
  localparam logic [LVL_W-1:0] LVL_HALF  = LVL_W'(BUFFER_DEPTH / 2);
  localparam logic [LVL_W-1:0] LVL_HALF1 = LVL_W'(BUFFER_DEPTH / 2 + 1);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             run_active;
  logic             enter_run;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_eff;
  logic             cnt_at_end;
  logic             tick_fire;

  logic [47:0]      mem [BUFFER_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] level;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop_ok;
  logic             push_ok;
  logic             wr_drop;
  logic             irq_set;

  // Playback state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_STOP;
    end else begin
      state <= state_nxt;
    end
  end

  // Playback transitions follow play_in directly; clear does not touch the state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP: if (play_in)  state_nxt = ST_RUN;
      ST_RUN:  if (!play_in) state_nxt = ST_STOP;
      default: state_nxt = ST_STOP;
    endcase
  end

  // Decoded state outputs: counting only while RUN stays in RUN this edge
  always_comb begin
    run_active = 1'b0;
    enter_run  = 1'b0;
    case (state)
      ST_STOP: enter_run  = play_in;
      ST_RUN:  run_active = play_in;
      default: begin
        run_active = 1'b0;
        enter_run  = 1'b0;
      end
    endcase
  end

  // Divider values below 2 are clamped so a tick can never be issued every cycle
  assign div_eff    = (rate_div_in < DIV_W'(2)) ? DIV_W'(2) : rate_div_in;
  // >= rather than == so a shrinking divider fires on the next edge instead of waiting a wrap
  assign cnt_at_end = (cnt >= (div_eff - DIV_W'(1)));
  assign tick_fire  = run_active && cnt_at_end && !clr_in;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_FULL);
  assign pop_ok     = tick_fire && !fifo_empty;
  // A tick on the same edge frees a slot, so a full FIFO still accepts the write
  assign push_ok    = wr_in && !clr_in && (!fifo_full || tick_fire);
  assign wr_drop    = wr_in && !clr_in && fifo_full && !tick_fire;
  assign irq_set    = (tick_fire && !push_ok && (level == LVL_HALF1)) ||
                      (enter_run && (level <= LVL_HALF));

  // Sample-period divider and registered tick pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      tick_out <= 1'b0;
    end else begin
      tick_out <= tick_fire;
      if (clr_in || !run_active || tick_fire) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

  // Pair storage; contents survive reset but become unreachable once pointers reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata_in;
    end
  end

  // Read/write pointers wrap naturally; the level counter disambiguates full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (clr_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Output pair register: loads the head on a tick, zeros when the tick finds nothing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abuf_out     <= '0;
      underrun_out <= 1'b0;
    end else if (clr_in) begin
      abuf_out     <= '0;
      underrun_out <= 1'b0;
    end else if (tick_fire) begin
      if (fifo_empty) begin
        abuf_out     <= '0;
        underrun_out <= 1'b1;
      end else begin
        abuf_out     <= mem[rd_ptr];
      end
    end
  end

  // Refill interrupt: set beats acknowledge, clear beats both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_out <= 1'b0;
    end else if (clr_in) begin
      irq_out <= 1'b0;
    end else if (irq_set) begin
      irq_out <= 1'b1;
    end else if (irq_ack_in) begin
      irq_out <= 1'b0;
    end
  end

  // Dropped-write pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_out <= 1'b0;
    end else begin
      wr_err_out <= wr_drop;
    end
  end

  assign level_out = level;
  assign full_out  = fifo_full;

endmodule
